// File: rtl/enemy_pkg.sv
// Shared enemy/sprite definitions: draw-sequencer state encoding and the
// default pixel-bus widths used by the drawers, collision detector and VGA path.
package enemy_pkg;

  localparam int X_W_DEF      = 9;
  localparam int Y_W_DEF      = 8;
  localparam int COLOUR_W_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_GRANT   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_index #(
  parameter int W = 3,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scan from the top down so the last hit (lowest bit) wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_draw_sequencer.sv
// Draw arbiter: grants each alive sprite drawer in ascending order, muxes the
// granted drawer's pixel stream to the VGA port, and guards each grant with a
// watchdog so a hung drawer cannot stall the frame.
import enemy_pkg::*;

module enemy_draw_sequencer #(
  parameter int NUM_CH    = 3,
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int COLOUR_W  = COLOUR_W_DEF,
  parameter int TIMEOUT_W = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       draw,
  input  logic [NUM_CH-1:0]          alive,
  input  logic [NUM_CH*X_W-1:0]      ch_x_draw,
  input  logic [NUM_CH*Y_W-1:0]      ch_y_draw,
  input  logic [NUM_CH*COLOUR_W-1:0] ch_colour,
  input  logic [NUM_CH-1:0]          ch_vga_write,
  input  logic [NUM_CH-1:0]          ch_draw_done,
  output logic [NUM_CH-1:0]          ch_draw,
  output logic [X_W-1:0]             x_draw,
  output logic [Y_W-1:0]             y_draw,
  output logic [COLOUR_W-1:0]        colour,
  output logic                       VGA_write,
  output logic                       draw_done,
  output logic                       timeout_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt, enc_idx;
  logic [NUM_CH-1:0]    mask, mask_nxt, pend;
  logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
  logic                 terr_nxt, enc_valid, gnt;

  // Channels still pending at or above the current index.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_CH; i++) pend[i] = mask[i] && (i >= int'(idx));
  end

  lowest_set_index #(.W(NUM_CH)) u_lsi (
    .vec   (pend),
    .valid (enc_valid),
    .index (enc_idx)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      mask        <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      mask        <= mask_nxt;
      wdog        <= wdog_nxt;
      timeout_err <= terr_nxt;
    end
  end

  // Next-state: walk the alive mask; dropping draw aborts back to IDLE from any active state.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask;
    wdog_nxt  = wdog;
    terr_nxt  = timeout_err;
    case (state)
      S_IDLE: begin
        idx_nxt = '0;
        if (draw) begin
          mask_nxt  = alive;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!draw) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else if (!enc_valid) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = enc_idx;
          wdog_nxt  = '0;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!draw) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else if (wdog == '1) begin
          // Expiry wins over a coincident done so the hang is still reported.
          terr_nxt  = 1'b1;
          state_nxt = S_RELEASE;
        end else begin
          wdog_nxt = wdog + 1'b1;
          if (ch_draw_done[idx]) state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!draw) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else begin
          mask_nxt[idx] = 1'b0;
          if (idx == IDX_W'(NUM_CH - 1)) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_SELECT;
          end
        end
      end
      S_DONE: begin
        if (!draw) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant and pixel mux; gated by draw so an abort drops the stream in the same cycle.
  always_comb begin
    gnt       = (state == S_GRANT) && draw;
    ch_draw   = '0;
    x_draw    = '0;
    y_draw    = '0;
    colour    = '0;
    VGA_write = 1'b0;
    draw_done = (state == S_DONE);
    if (gnt) begin
      ch_draw[idx] = 1'b1;
      x_draw       = ch_x_draw[int'(idx)*X_W +: X_W];
      y_draw       = ch_y_draw[int'(idx)*Y_W +: Y_W];
      colour       = ch_colour[int'(idx)*COLOUR_W +: COLOUR_W];
      VGA_write    = ch_vga_write[idx];
    end
  end

endmodule

// File: tb/tb_enemy_draw_sequencer.sv
// Directed bench for enemy_draw_sequencer: a 3-channel instance with a short
// watchdog and an 8-channel instance fed random pixel data.
import enemy_pkg::*;

module tb_enemy_draw_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- 3-channel instance, TIMEOUT_W=4 ----------------
  logic       draw_a;
  logic [2:0] alive_a, vga_a, done_a, chd_a, hang;
  logic [26:0] chx_a;
  logic [23:0] chy_a;
  logic [17:0] chc_a;
  logic [8:0] x_a;
  logic [7:0] y_a;
  logic [5:0] c_a;
  logic       w_a, dd_a, te_a;
  int         cnt_a [3];

  enemy_draw_sequencer #(.NUM_CH(3), .TIMEOUT_W(4)) dut_a (
    .clock(clock), .reset(reset), .draw(draw_a), .alive(alive_a),
    .ch_x_draw(chx_a), .ch_y_draw(chy_a), .ch_colour(chc_a),
    .ch_vga_write(vga_a), .ch_draw_done(done_a), .ch_draw(chd_a),
    .x_draw(x_a), .y_draw(y_a), .colour(c_a), .VGA_write(w_a),
    .draw_done(dd_a), .timeout_err(te_a)
  );

  // Drawer model: done in the 5th granted cycle, held while granted; hung drawers never finish.
  always_ff @(posedge clock) for (int i = 0; i < 3; i++) cnt_a[i] <= chd_a[i] ? cnt_a[i] + 1 : 0;
  always_comb begin
    done_a = '0;
    for (int i = 0; i < 3; i++) done_a[i] = chd_a[i] && !hang[i] && (cnt_a[i] >= 4);
  end

  // ---------------- 8-channel instance ----------------
  logic       draw_b;
  logic [7:0] alive_b, vga_b, done_b, chd_b;
  logic [71:0] chx_b;
  logic [63:0] chy_b;
  logic [47:0] chc_b;
  logic [8:0] x_b;
  logic [7:0] y_b;
  logic [5:0] c_b;
  logic       w_b, dd_b, te_b;
  int         cnt_b [8];

  enemy_draw_sequencer #(.NUM_CH(8)) dut_b (
    .clock(clock), .reset(reset), .draw(draw_b), .alive(alive_b),
    .ch_x_draw(chx_b), .ch_y_draw(chy_b), .ch_colour(chc_b),
    .ch_vga_write(vga_b), .ch_draw_done(done_b), .ch_draw(chd_b),
    .x_draw(x_b), .y_draw(y_b), .colour(c_b), .VGA_write(w_b),
    .draw_done(dd_b), .timeout_err(te_b)
  );

  always_ff @(posedge clock) for (int i = 0; i < 8; i++) cnt_b[i] <= chd_b[i] ? cnt_b[i] + 1 : 0;
  always_comb begin
    done_b = '0;
    for (int i = 0; i < 8; i++) done_b[i] = chd_b[i] && (cnt_b[i] >= 4);
  end

  // ---------------- frame monitor for instance A ----------------
  int lat, ord, mux_err, ovl_err, x1_seen;
  int gcyc [3];

  // Raise draw and watch one frame; k=0 is the first edge that samples draw.
  task automatic run_a(input int budget);
    logic [2:0] prev;
    int j;
    lat = -1; ord = 0; mux_err = 0; ovl_err = 0; x1_seen = 0; prev = '0;
    for (int i = 0; i < 3; i++) gcyc[i] = 0;
    draw_a = 1'b1;
    for (int k = 0; k < budget && lat < 0; k++) begin
      tick();
      j = -1;
      case (chd_a)
        3'b001: j = 0;
        3'b010: j = 1;
        3'b100: j = 2;
        default: j = -1;
      endcase
      if (j >= 0) begin
        gcyc[j]++;
        if (chd_a != prev) ord = ord * 10 + j + 1;
        if (x_a != 9'(100 + j) || y_a != 8'(50 + j) || c_a != 6'(j + 1) || !w_a) mux_err++;
      end else if (chd_a == 3'b000) begin
        if (x_a != 0 || y_a != 0 || c_a != 0 || w_a) mux_err++;
      end else mux_err++;
      if (x_a == 9'd101) x1_seen++;
      if (dd_a && chd_a != 0) ovl_err++;
      if (dd_a) lat = k;
      prev = chd_a;
    end
  endtask

  task automatic end_frame();
    draw_a = 1'b0;
    tick();
    tick();
  endtask

  int g7, bad7, wr7, lat_b, waitc;

  initial begin
    draw_a = 0; alive_a = 3'b111; hang = '0; vga_a = 3'b111;
    for (int i = 0; i < 3; i++) begin
      chx_a[i*9 +: 9] = 9'(100 + i);
      chy_a[i*8 +: 8] = 8'(50 + i);
      chc_a[i*6 +: 6] = 6'(i + 1);
    end
    draw_b = 0; alive_b = 8'h80; vga_b = '0; chx_b = '0; chy_b = '0; chc_b = '0;

    // Reset state
    tick(); tick();
    chk("rst_ch_draw", 32'(chd_a), 0);
    chk("rst_outputs", 32'({x_a, y_a, c_a, w_a, dd_a}), 0);
    chk("rst_timeout_err", 32'(te_a), 0);
    reset = 1'b1;
    tick();

    // 1: all alive, grants 0,1,2 each for 5 cycles, done after 21
    run_a(60);
    chk("t1_latency", 32'(lat), 21);
    chk("t1_order", 32'(ord), 123);
    chk("t1_g0_cycles", 32'(gcyc[0]), 5);
    chk("t1_g2_cycles", 32'(gcyc[2]), 5);
    chk("t1_mux", 32'(mux_err), 0);
    chk("t1_done_overlap", 32'(ovl_err), 0);
    chk("t1_timeout_err", 32'(te_a), 0);
    end_frame();
    chk("t1_done_drop", 32'(dd_a), 0);

    // 2: channel 1 dead, skipped, 7 cycles faster
    alive_a = 3'b101;
    run_a(60);
    alive_a = 3'b111;
    chk("t2_latency", 32'(lat), 14);
    chk("t2_order", 32'(ord), 13);
    chk("t2_g1_cycles", 32'(gcyc[1]), 0);
    chk("t2_x1_seen", 32'(x1_seen), 0);
    chk("t2_mux", 32'(mux_err), 0);
    end_frame();

    // 3: drawer 1 hangs; watchdog releases after 16 grant cycles
    hang = 3'b010;
    run_a(80);
    hang = '0;
    chk("t3_g1_cycles", 32'(gcyc[1]), 16);
    chk("t3_g2_cycles", 32'(gcyc[2]), 5);
    chk("t3_latency", 32'(lat), 32);
    chk("t3_timeout_err", 32'(te_a), 1);
    chk("t3_done_overlap", 32'(ovl_err), 0);
    end_frame();
    chk("t3_err_sticky", 32'(te_a), 1);

    // 4: abort while channel 1 is granted, then restart from channel 0
    draw_a = 1'b1;
    waitc = 0;
    while (!chd_a[1] && waitc < 40) begin tick(); waitc++; end
    chk("t4_reached_ch1", 32'(chd_a[1]), 1);
    draw_a = 1'b0;
    tick();
    chk("t4_ch_draw", 32'(chd_a), 0);
    chk("t4_vga_write", 32'(w_a), 0);
    chk("t4_state_idle", 32'(dut_a.state), 32'(S_IDLE));
    chk("t4_no_done", 32'(dd_a), 0);
    draw_a = 1'b1;
    tick();
    tick();
    chk("t4_restart_ch0", 32'(chd_a), 32'(3'b001));

    // 5: async reset between edges during a grant
    tick();
    #2 reset = 1'b0;
    #1;
    chk("t5_ch_draw", 32'(chd_a), 0);
    chk("t5_pixel", 32'({x_a, y_a, c_a, w_a}), 0);
    chk("t5_timeout_err", 32'(te_a), 0);
    chk("t5_draw_done", 32'(dd_a), 0);
    draw_a = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // 6: 8 channels, only ch7 alive, random pixel data must pass bit-exact
    g7 = 0; bad7 = 0; wr7 = 0; lat_b = -1;
    draw_b = 1'b1;
    for (int k = 0; k < 30 && lat_b < 0; k++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++) begin
        chx_b[i*9 +: 9] = 9'($urandom);
        chy_b[i*8 +: 8] = 8'($urandom);
        chc_b[i*6 +: 6] = 6'($urandom);
        vga_b[i]        = 1'($urandom);
      end
      #2;
      if (chd_b == 8'h80) begin
        g7++;
        if (x_b != chx_b[63 +: 9] || y_b != chy_b[56 +: 8] || c_b != chc_b[42 +: 6] || w_b != vga_b[7]) bad7++;
        if (w_b) wr7++;
      end else if (chd_b == 8'h00) begin
        if (x_b != 0 || y_b != 0 || c_b != 0 || w_b) bad7++;
      end else bad7++;
      if (dd_b) lat_b = k;
    end
    chk("t6_ch7_cycles", 32'(g7), 5);
    chk("t6_stream", 32'(bad7), 0);
    chk("t6_latency", 32'(lat_b), 7);
    chk("t6_writes_seen", 32'(wr7 > 0), 1);
    draw_b = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
